multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle main control sequencer for the RV32I core. It sits directly upstream of `ALU_control_unit`. It decodes the opcode held in the instruction register and produces the 3-bit `alu_op` that `ALU_control_unit` consumes. It also drives every datapath enable, mux select and the instruction/data memory handshake, one state per cycle. It counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `opcode`  in  7: `instr[6:0]` from the instruction register; stable between `ir_write` pulses.
- `mem_ready`  in  1: memory completes the pending access in this cycle.
- `branch_taken`  in  1: ALU compare result, valid in the BRANCH state.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: write strobe, qualified by `mem_req`.
- `mem_addr_src`  out  1: 0 selects PC, 1 selects ALUOut.
- `ir_write`  out  1: load the instruction register.
- `pc_write`  out  1: load the PC.
- `pc_src`  out  1: 0 selects the live ALU result, 1 selects ALUOut.
- `reg_write`  out  1: register file write.
- `alu_op`  out  3: `ALU_OP_*` code from defs.v, feeds `ALU_control_unit`.
- `alu_src_a`  out  2: 00 PC, 01 old_pc, 10 rs1.
- `alu_src_b`  out  2: 00 rs2, 01 imm, 10 constant 4.
- `result_src`  out  2: 00 ALUOut, 01 mem data, 10 PC.
- `illegal_instr`  out  1: high while in TRAP.
- `state`  out  4: current state, for debug.
- `instr_retired`  out  COUNT_W: retired-instruction count.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, EXEC_U=5, MEM_ADDR=6, MEM_READ=7, MEM_WRITE=8, WB_ALU=9, WB_MEM=10, BRANCH=11, JAL=12, TRAP=15. Unused codes go to TRAP.
- Outputs are registered-state decodes (Moore). The exception is FETCH, where `ir_write` and `pc_write` equal `mem_ready`. Any output not listed below is 0.
- IDLE: no outputs. Goes to FETCH unconditionally.
- FETCH:
  - `mem_req`=1, `mem_addr_src`=0.
  - ALU computes PC+4: `alu_src_a`=00, `alu_src_b`=10, `alu_op`=`ALU_OP_LW_SW_type`, `pc_src`=0.
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE: computes the branch/jump target old_pc+imm into ALUOut (`alu_src_a`=01, `alu_src_b`=01, `alu_op`=`ALU_OP_LW_SW_type`). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111, 0010111 → EXEC_U
  - 0000011, 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=`ALU_OP_R_type`. Goes to WB_ALU.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=`ALU_OP_I_type`. Goes to WB_ALU.
- EXEC_U: `alu_src_a`=01, `alu_src_b`=01. `alu_op`=`ALU_OP_LUI_type` for 0110111, `ALU_OP_AUIPC_type` for 0010111. Goes to WB_ALU.
- MEM_ADDR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=`ALU_OP_LW_SW_type`. Goes to MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: `mem_req`=1, `mem_addr_src`=1. Waits for `mem_ready`, then goes to WB_MEM.
- MEM_WRITE: `mem_req`=1, `mem_we`=1, `mem_addr_src`=1. Waits for `mem_ready`, then goes to FETCH. The instruction retires.
- WB_ALU: `reg_write`=1, `result_src`=00. Goes to FETCH and retires.
- WB_MEM: `reg_write`=1, `result_src`=01. Goes to FETCH and retires.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=`ALU_OP_CB_type`, `pc_src`=1, `pc_write`=`branch_taken` (the single permitted Mealy term outside FETCH). Goes to FETCH and retires.
- JAL: `reg_write`=1, `result_src`=10 (PC already holds PC+4), `pc_write`=1, `pc_src`=1. Goes to FETCH and retires.
- TRAP: `illegal_instr`=1. Absorbing; only `rst_n` exits. Does not retire.
- Retire counter:
  - `instr_retired` increments by 1 on each transition into FETCH from MEM_WRITE, WB_ALU, WB_MEM, BRANCH or JAL.
  - Wraps from 2^COUNT_W−1 to 0.
  - The IDLE→FETCH transition does not count.
- Memory handshake: `mem_req`, `mem_we` and the address select stay constant until the cycle in which `mem_ready`=1. A `mem_ready` seen in any state other than FETCH, MEM_READ or MEM_WRITE is ignored.

## Timing
- Reset: when `rst_n` is low, state is IDLE immediately (asynchronous), `instr_retired`=0, and all outputs are 0, `alu_op` included.
- Reset asserted mid-access, including MEM_WRITE, drops `mem_req` and `mem_we` in the same cycle.
- First FETCH occurs one cycle after `rst_n` rises.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - R, I, LUI, AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL: 3 cycles.
- Each extra cycle `mem_ready` stays low adds 1 cycle.
- `opcode` is sampled only in DECODE, EXEC_U and MEM_ADDR. It must not change between `ir_write` pulses.

## Test plan
- Reset release, then `add x3,x1,x2` (opcode 0110011), `mem_ready` always 1 → states 0,1,2,3,9,1. `alu_op`=`ALU_OP_R_type` in EXEC_R. `reg_write` high exactly one cycle. `instr_retired` 0→1.
- Load (0000011) with `mem_ready` low for 2 cycles in both FETCH and MEM_READ → 9 cycles total. `mem_req` and `mem_addr_src` are stable while waiting. `result_src`=01 in WB_MEM.
- Branch (1100011) with `branch_taken`=1, then again with 0 → `pc_write`=1 with `pc_src`=1 in BRANCH only in the first case. Both take 3 cycles and both increment the counter.
- Opcode 1111111 → TRAP (15) after DECODE, `illegal_instr`=1 held for 20 cycles, counter frozen. A `rst_n` pulse returns to IDLE.
- `rst_n` dropped during MEM_WRITE → `mem_req`=0, `mem_we`=0 and `state`=0 in the same cycle, counter reads 0.
- COUNT_W=4, 17 back-to-back `addi` (0010011) → counter reads 15 after 15 instructions, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multi-cycle main control sequencer for the RV32I core.
//                Decodes the instruction-register opcode, sequences one
//                datapath step per cycle, drives the memory handshake,
//                produces alu_op for ALU_control_unit, counts retired
//                instructions and traps on unsupported opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   input  logic               branch_taken,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_addr_src,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_src,
   output logic               reg_write,
   output logic [2:0]         alu_op,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         result_src,
   output logic               illegal_instr,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instr_retired
);

   // ALU_OP_* codes shared with ALU_control_unit (defs.v)
   localparam logic [2:0] c_ALU_OP_LW_SW_TYPE = 3'b000;
   localparam logic [2:0] c_ALU_OP_CB_TYPE    = 3'b001;
   localparam logic [2:0] c_ALU_OP_R_TYPE     = 3'b010;
   localparam logic [2:0] c_ALU_OP_I_TYPE     = 3'b011;
   localparam logic [2:0] c_ALU_OP_LUI_TYPE   = 3'b100;
   localparam logic [2:0] c_ALU_OP_AUIPC_TYPE = 3'b101;

   // RV32I major opcodes
   localparam logic [6:0] c_OPC_R      = 7'b0110011;
   localparam logic [6:0] c_OPC_I      = 7'b0010011;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

   // Mux select encodings
   localparam logic [1:0] c_SRC_A_PC     = 2'b00;
   localparam logic [1:0] c_SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] c_SRC_A_RS1    = 2'b10;
   localparam logic [1:0] c_SRC_B_RS2    = 2'b00;
   localparam logic [1:0] c_SRC_B_IMM    = 2'b01;
   localparam logic [1:0] c_SRC_B_FOUR   = 2'b10;
   localparam logic [1:0] c_RES_ALUOUT   = 2'b00;
   localparam logic [1:0] c_RES_MEM      = 2'b01;
   localparam logic [1:0] c_RES_PC       = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_EXEC_I    = 4'd4,
      S_EXEC_U    = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_WB_ALU    = 4'd9,
      S_WB_MEM    = 4'd10,
      S_BRANCH    = 4'd11,
      S_JAL       = 4'd12,
      S_TRAP      = 4'd15
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_retire;
   logic                 w_in_fetch;
   logic                 w_in_branch;

   logic                 r_mem_req;
   logic                 r_mem_we;
   logic                 r_mem_addr_src;
   logic                 r_pc_write_jal;
   logic                 r_pc_src;
   logic                 r_reg_write;
   logic [2:0]           r_alu_op;
   logic [1:0]           r_alu_src_a;
   logic [1:0]           r_alu_src_b;
   logic [1:0]           r_result_src;
   logic                 r_illegal;
   logic [COUNT_W-1:0]   r_count;

   // Next-state selection; unused encodings fall into TRAP
   always_comb begin
      w_state_next = S_TRAP;
      case (r_state)
         S_IDLE:      w_state_next = S_FETCH;
         S_FETCH:     w_state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               c_OPC_R:                   w_state_next = S_EXEC_R;
               c_OPC_I:                   w_state_next = S_EXEC_I;
               c_OPC_LUI, c_OPC_AUIPC:    w_state_next = S_EXEC_U;
               c_OPC_LOAD, c_OPC_STORE:   w_state_next = S_MEM_ADDR;
               c_OPC_BRANCH:              w_state_next = S_BRANCH;
               c_OPC_JAL:                 w_state_next = S_JAL;
               default:                   w_state_next = S_TRAP;
            endcase
         end
         S_EXEC_R:    w_state_next = S_WB_ALU;
         S_EXEC_I:    w_state_next = S_WB_ALU;
         S_EXEC_U:    w_state_next = S_WB_ALU;
         S_MEM_ADDR:  w_state_next = (opcode == c_OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  w_state_next = mem_ready ? S_WB_MEM : S_MEM_READ;
         S_MEM_WRITE: w_state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_WB_ALU:    w_state_next = S_FETCH;
         S_WB_MEM:    w_state_next = S_FETCH;
         S_BRANCH:    w_state_next = S_FETCH;
         S_JAL:       w_state_next = S_FETCH;
         S_TRAP:      w_state_next = S_TRAP;
         default:     w_state_next = S_TRAP;
      endcase
   end

   // An instruction retires when its last step hands control back to FETCH;
   // the IDLE->FETCH start-up hop is deliberately excluded
   always_comb begin
      w_retire = 1'b0;
      if (w_state_next == S_FETCH) begin
         case (r_state)
            S_MEM_WRITE, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: w_retire = 1'b1;
            default:                                          w_retire = 1'b0;
         endcase
      end
   end

   // State, Moore outputs (decoded from the upcoming state) and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr_src <= 1'b0;
         r_pc_write_jal <= 1'b0;
         r_pc_src       <= 1'b0;
         r_reg_write    <= 1'b0;
         r_alu_op       <= c_ALU_OP_LW_SW_TYPE;
         r_alu_src_a    <= c_SRC_A_PC;
         r_alu_src_b    <= c_SRC_B_RS2;
         r_result_src   <= c_RES_ALUOUT;
         r_illegal      <= 1'b0;
         r_count        <= '0;
      end else begin
         r_state        <= w_state_next;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr_src <= 1'b0;
         r_pc_write_jal <= 1'b0;
         r_pc_src       <= 1'b0;
         r_reg_write    <= 1'b0;
         r_alu_op       <= c_ALU_OP_LW_SW_TYPE;
         r_alu_src_a    <= c_SRC_A_PC;
         r_alu_src_b    <= c_SRC_B_RS2;
         r_result_src   <= c_RES_ALUOUT;
         r_illegal      <= 1'b0;
         case (w_state_next)
            S_FETCH: begin
               r_mem_req   <= 1'b1;
               r_alu_src_a <= c_SRC_A_PC;
               r_alu_src_b <= c_SRC_B_FOUR;
               r_alu_op    <= c_ALU_OP_LW_SW_TYPE;
            end
            S_DECODE: begin
               r_alu_src_a <= c_SRC_A_OLD_PC;
               r_alu_src_b <= c_SRC_B_IMM;
               r_alu_op    <= c_ALU_OP_LW_SW_TYPE;
            end
            S_EXEC_R: begin
               r_alu_src_a <= c_SRC_A_RS1;
               r_alu_src_b <= c_SRC_B_RS2;
               r_alu_op    <= c_ALU_OP_R_TYPE;
            end
            S_EXEC_I: begin
               r_alu_src_a <= c_SRC_A_RS1;
               r_alu_src_b <= c_SRC_B_IMM;
               r_alu_op    <= c_ALU_OP_I_TYPE;
            end
            S_EXEC_U: begin
               r_alu_src_a <= c_SRC_A_OLD_PC;
               r_alu_src_b <= c_SRC_B_IMM;
               r_alu_op    <= (opcode == c_OPC_LUI) ? c_ALU_OP_LUI_TYPE : c_ALU_OP_AUIPC_TYPE;
            end
            S_MEM_ADDR: begin
               r_alu_src_a <= c_SRC_A_RS1;
               r_alu_src_b <= c_SRC_B_IMM;
               r_alu_op    <= c_ALU_OP_LW_SW_TYPE;
            end
            S_MEM_READ: begin
               r_mem_req      <= 1'b1;
               r_mem_addr_src <= 1'b1;
            end
            S_MEM_WRITE: begin
               r_mem_req      <= 1'b1;
               r_mem_we       <= 1'b1;
               r_mem_addr_src <= 1'b1;
            end
            S_WB_ALU: begin
               r_reg_write  <= 1'b1;
               r_result_src <= c_RES_ALUOUT;
            end
            S_WB_MEM: begin
               r_reg_write  <= 1'b1;
               r_result_src <= c_RES_MEM;
            end
            S_BRANCH: begin
               r_alu_src_a <= c_SRC_A_RS1;
               r_alu_src_b <= c_SRC_B_RS2;
               r_alu_op    <= c_ALU_OP_CB_TYPE;
               r_pc_src    <= 1'b1;
            end
            S_JAL: begin
               r_reg_write    <= 1'b1;
               r_result_src   <= c_RES_PC;
               r_pc_write_jal <= 1'b1;
               r_pc_src       <= 1'b1;
            end
            S_TRAP: begin
               r_illegal <= 1'b1;
            end
            default: begin
               r_illegal <= 1'b0;
            end
         endcase
         if (w_retire) begin
            r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   // FETCH loads IR/PC in the cycle memory answers; BRANCH commits the PC on the live compare
   assign w_in_fetch  = (r_state == S_FETCH);
   assign w_in_branch = (r_state == S_BRANCH);

   assign ir_write      = w_in_fetch & mem_ready;
   assign pc_write      = (w_in_fetch & mem_ready) | (w_in_branch & branch_taken) | r_pc_write_jal;
   assign mem_req       = r_mem_req;
   assign mem_we        = r_mem_we;
   assign mem_addr_src  = r_mem_addr_src;
   assign pc_src        = r_pc_src;
   assign reg_write     = r_reg_write;
   assign alu_op        = r_alu_op;
   assign alu_src_a     = r_alu_src_a;
   assign alu_src_b     = r_alu_src_b;
   assign result_src    = r_result_src;
   assign illegal_instr = r_illegal;
   assign state         = r_state;
   assign instr_retired = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Self-checking bench for multicycle_control_fsm; a per-
//                instruction path model plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   localparam logic [2:0] AO_LWSW  = 3'd0;
   localparam logic [2:0] AO_CB    = 3'd1;
   localparam logic [2:0] AO_R     = 3'd2;
   localparam logic [2:0] AO_I     = 3'd3;
   localparam logic [2:0] AO_LUI   = 3'd4;
   localparam logic [2:0] AO_AUIPC = 3'd5;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        branch_taken;

   logic        mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, reg_write, illegal_instr;
   logic [2:0]  alu_op;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [3:0]  state;
   logic [31:0] instr_retired;

   logic        mem_req4, mem_we4, mem_addr_src4, ir_write4, pc_write4, pc_src4, reg_write4, illegal_instr4;
   logic [2:0]  alu_op4;
   logic [1:0]  alu_src_a4, alu_src_b4, result_src4;
   logic [3:0]  state4;
   logic [3:0]  instr_retired4;

   int checks = 0;
   int errors = 0;
   bit m_en   = 1'b1;

   multicycle_control_fsm #(.COUNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .illegal_instr(illegal_instr), .state(state), .instr_retired(instr_retired)
   );

   multicycle_control_fsm #(.COUNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr_src(mem_addr_src4), .ir_write(ir_write4),
      .pc_write(pc_write4), .pc_src(pc_src4), .reg_write(reg_write4), .alu_op(alu_op4),
      .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .result_src(result_src4),
      .illegal_instr(illegal_instr4), .state(state4), .instr_retired(instr_retired4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [16:0] w_outs  = {mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, reg_write,
                          alu_op, alu_src_a, alu_src_b, result_src, illegal_instr};
   wire [16:0] w_outs4 = {mem_req4, mem_we4, mem_addr_src4, ir_write4, pc_write4, pc_src4, reg_write4,
                          alu_op4, alu_src_a4, alu_src_b4, result_src4, illegal_instr4};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Output table: what each phase of an instruction must drive
   function automatic logic [16:0] spec_outs(input int s, input logic [6:0] op, input logic rdy, input logic bt);
      logic req, we, asrc, irw, pcw, pcs, rw, ill;
      logic [2:0] ao;
      logic [1:0] a, b, rs;
      req = 0; we = 0; asrc = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; ill = 0;
      ao = AO_LWSW; a = 0; b = 0; rs = 0;
      case (s)
         1:  begin req = 1; irw = rdy; pcw = rdy; b = 2; end
         2:  begin a = 1; b = 1; end
         3:  begin a = 2; ao = AO_R; end
         4:  begin a = 2; b = 1; ao = AO_I; end
         5:  begin a = 1; b = 1; ao = (op == OP_LUI) ? AO_LUI : AO_AUIPC; end
         6:  begin a = 2; b = 1; end
         7:  begin req = 1; asrc = 1; end
         8:  begin req = 1; we = 1; asrc = 1; end
         9:  rw = 1;
         10: begin rw = 1; rs = 1; end
         11: begin a = 2; ao = AO_CB; pcs = 1; pcw = bt; end
         12: begin rw = 1; rs = 2; pcw = 1; pcs = 1; end
         15: ill = 1;
         default: ;
      endcase
      return {req, we, asrc, irw, pcw, pcs, rw, ao, a, b, rs, ill};
   endfunction

   // Model: each instruction is a fixed path of phases after DECODE; waits stretch memory phases
   int m_st  = 0;
   int m_cnt = 0;
   int m_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_cnt = 0; m_q.delete();
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 15) begin
         m_st = 15;
      end else if ((m_st == 1 || m_st == 7 || m_st == 8) && !mem_ready) begin
         m_st = m_st;
      end else if (m_st == 1) begin
         m_st = 2;
         m_q.delete();
         case (opcode)
            OP_R:            begin m_q.push_back(3); m_q.push_back(9); end
            OP_I:            begin m_q.push_back(4); m_q.push_back(9); end
            OP_LUI, OP_AUIPC: begin m_q.push_back(5); m_q.push_back(9); end
            OP_LD:           begin m_q.push_back(6); m_q.push_back(7); m_q.push_back(10); end
            OP_ST:           begin m_q.push_back(6); m_q.push_back(8); end
            OP_BR:           m_q.push_back(11);
            OP_JAL:          m_q.push_back(12);
            default:         m_q.push_back(15);
         endcase
      end else if (m_q.size() > 0) begin
         m_st = m_q.pop_front();
      end else begin
         m_st = 1;
         m_cnt++;
      end
   end

   // Cycle-by-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (m_en) begin
         chk("model_state",  32'(state), m_st);
         chk("model_outs",   32'(w_outs), 32'(spec_outs(m_st, opcode, mem_ready, branch_taken)));
         chk("model_count",  instr_retired, m_cnt);
         chk("model_state4", 32'(state4), m_st);
         chk("model_outs4",  32'(w_outs4), 32'(spec_outs(m_st, opcode, mem_ready, branch_taken)));
         chk("model_count4", 32'(instr_retired4), m_cnt % 16);
      end
   end

   task automatic cyc(input logic [6:0] op, input logic rdy, input logic bt, input int exp_st);
      @(posedge clk); #1;
      opcode = op; mem_ready = rdy; branch_taken = bt;
      @(negedge clk);
      chk("state_seq", 32'(state), exp_st);
   endtask

   initial begin
      rst_n = 1'b1; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_outs", 32'(w_outs), 0);
      chk("rst_count", instr_retired, 0);

      // add x3,x1,x2
      @(posedge clk); #1; rst_n = 1'b1; opcode = OP_R; mem_ready = 1'b1;
      @(negedge clk); chk("release_idle", 32'(state), 0);
      cyc(OP_R, 1, 0, 1);  chk("add_ir_write", 32'(ir_write), 1);
      cyc(OP_R, 1, 0, 2);
      cyc(OP_R, 1, 0, 3);  chk("add_alu_op", 32'(alu_op), 32'(AO_R));
      cyc(OP_R, 1, 0, 9);  chk("add_reg_write", 32'(reg_write), 1); chk("add_cnt_before", instr_retired, 0);

      // load, two wait cycles in FETCH and in MEM_READ
      cyc(OP_LD, 0, 0, 1); chk("add_retired", instr_retired, 1); chk("ld_ir_hold", 32'(ir_write), 0);
      cyc(OP_LD, 0, 0, 1);
      cyc(OP_LD, 1, 0, 1);
      cyc(OP_LD, 1, 0, 2);
      cyc(OP_LD, 1, 0, 6);
      cyc(OP_LD, 0, 0, 7); chk("ld_wait_req", 32'({mem_req, mem_addr_src}), 3);
      cyc(OP_LD, 0, 0, 7); chk("ld_wait_req2", 32'({mem_req, mem_addr_src}), 3);
      cyc(OP_LD, 1, 0, 7);
      cyc(OP_LD, 1, 0, 10); chk("ld_result_src", 32'(result_src), 1);

      // branch taken, then not taken
      cyc(OP_BR, 1, 0, 1); chk("ld_retired", instr_retired, 2);
      cyc(OP_BR, 1, 0, 2);
      cyc(OP_BR, 1, 1, 11); chk("br_taken_pc", 32'({pc_write, pc_src}), 3);
      cyc(OP_BR, 1, 0, 1); chk("br1_retired", instr_retired, 3);
      cyc(OP_BR, 1, 0, 2);
      cyc(OP_BR, 1, 0, 11); chk("br_not_taken_pc", 32'(pc_write), 0);

      // LUI, AUIPC, JAL, store
      cyc(OP_LUI, 1, 0, 1); chk("br2_retired", instr_retired, 4);
      cyc(OP_LUI, 1, 0, 2);
      cyc(OP_LUI, 1, 0, 5); chk("lui_alu_op", 32'(alu_op), 32'(AO_LUI));
      cyc(OP_LUI, 1, 0, 9);
      cyc(OP_AUIPC, 1, 0, 1);
      cyc(OP_AUIPC, 1, 0, 2);
      cyc(OP_AUIPC, 1, 0, 5); chk("auipc_alu_op", 32'(alu_op), 32'(AO_AUIPC));
      cyc(OP_AUIPC, 1, 0, 9);
      cyc(OP_JAL, 1, 0, 1);
      cyc(OP_JAL, 1, 0, 2);
      cyc(OP_JAL, 1, 0, 12); chk("jal_ctl", 32'({pc_write, pc_src, reg_write, result_src}), 32'h1E);
      cyc(OP_ST, 1, 0, 1);
      cyc(OP_ST, 1, 0, 2);
      cyc(OP_ST, 1, 0, 6);
      cyc(OP_ST, 1, 0, 8); chk("st_we", 32'({mem_req, mem_we, mem_addr_src}), 7);

      // illegal opcode: absorbing TRAP, counter frozen, mem_ready ignored
      cyc(OP_BAD, 1, 0, 1); chk("st_retired", instr_retired, 8);
      cyc(OP_BAD, 1, 0, 2);
      for (int i = 0; i < 20; i++) begin
         cyc(OP_BAD, 1'(i % 2), 0, 15);
         chk("trap_illegal", 32'(illegal_instr), 1);
      end
      chk("trap_frozen", instr_retired, 8);

      // reset pulse leaves TRAP
      @(posedge clk); #1; rst_n = 1'b0; #1;
      chk("trap_rst_state", 32'(state), 0);
      chk("trap_rst_count", instr_retired, 0);
      @(posedge clk); #1; rst_n = 1'b1; opcode = OP_I; mem_ready = 1'b1;
      @(negedge clk); chk("rerelease_idle", 32'(state), 0);

      // addi, then a store interrupted by reset in MEM_WRITE
      cyc(OP_I, 1, 0, 1);
      cyc(OP_I, 1, 0, 2);
      cyc(OP_I, 1, 0, 4);
      cyc(OP_I, 1, 0, 9);
      cyc(OP_ST, 1, 0, 1); chk("addi_retired", instr_retired, 1);
      cyc(OP_ST, 1, 0, 2);
      cyc(OP_ST, 1, 0, 6);
      cyc(OP_ST, 0, 0, 8);
      #1 rst_n = 1'b0; #1;
      chk("midwrite_req_we", 32'({mem_req, mem_we}), 0);
      chk("midwrite_state", 32'(state), 0);
      chk("midwrite_count", instr_retired, 0);

      // 17 back-to-back addi; the 4-bit counter wraps
      @(posedge clk); #1; rst_n = 1'b1; opcode = OP_I; mem_ready = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 17; i++) begin
         cyc(OP_I, 1, 0, 1);
         if (i == 16) chk("cnt4_after15", 32'(instr_retired4), 15);
         if (i == 17) chk("cnt4_after16", 32'(instr_retired4), 0);
         cyc(OP_I, 1, 0, 2);
         cyc(OP_I, 1, 0, 4);
         cyc(OP_I, 1, 0, 9);
      end
      cyc(OP_I, 1, 0, 1);
      chk("cnt4_after17", 32'(instr_retired4), 1);
      chk("cnt32_after17", instr_retired, 17);

      m_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
